// File: rtl/array_rr_arbiter.sv
// Round-robin arbiter for M requesters on unpacked-array req/gnt ports; one owner at a time.
// Define ARB_TIMEOUT_EN to enable forced revoke after MAX_HOLD grant cycles, with a per-requester mask.
module array_rr_arbiter #(
   parameter  int unsigned M        = 4,
   parameter  int unsigned MAX_HOLD = 8,
   localparam int unsigned OW       = $clog2(M)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req [M],
   output logic          gnt [M],
   output logic          busy,
   output logic [OW-1:0] owner,
   output logic          timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state_q, state_d;
   logic          gnt_q   [M];
   logic          gnt_d   [M];
   logic [OW-1:0] owner_q, owner_d;
   logic          elig    [M];
   logic          win_vld;
   logic [OW-1:0] win_idx;
   logic [OW:0]   scan_sum;

`ifdef ARB_TIMEOUT_EN
   logic [7:0]    hold_q, hold_d;
   logic          mask_q  [M];
   logic          mask_d  [M];
   logic          timeout_q, timeout_d;

   always_comb begin
      for (int unsigned i = 0; i < M; i++) begin
         elig[i] = req[i] & ~mask_q[i];
      end
   end
`else
   always_comb begin
      for (int unsigned i = 0; i < M; i++) begin
         elig[i] = req[i];
      end
   end
`endif

   // Scan owner+1 .. owner+M; the wrap subtracts M so non-power-of-2 M never indexes past M-1.
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = owner_q;
      scan_sum = '0;
      for (int unsigned k = 1; k <= M; k++) begin
         scan_sum = {1'b0, owner_q} + (OW+1)'(k);
         if (scan_sum >= (OW+1)'(M)) begin
            scan_sum = scan_sum - (OW+1)'(M);
         end
         if (!win_vld && elig[scan_sum[OW-1:0]]) begin
            win_vld = 1'b1;
            win_idx = scan_sum[OW-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      for (int unsigned i = 0; i < M; i++) begin
         gnt_d[i] = 1'b0;
      end
`ifdef ARB_TIMEOUT_EN
      hold_d    = hold_q;
      timeout_d = 1'b0;
      for (int unsigned i = 0; i < M; i++) begin
         mask_d[i] = mask_q[i] & req[i];
      end
`endif
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d          = GRANT;
               owner_d          = win_idx;
               gnt_d[win_idx]   = 1'b1;
`ifdef ARB_TIMEOUT_EN
               hold_d           = '0;
`endif
            end
         end
         GRANT: begin
            if (!req[owner_q]) begin
               state_d = IDLE;
            end else begin
`ifdef ARB_TIMEOUT_EN
               // A voluntary drop takes the branch above, so revoke only fires with req still high.
               if ((32'(hold_q) + 32'd1) >= MAX_HOLD) begin
                  state_d          = IDLE;
                  timeout_d        = 1'b1;
                  mask_d[owner_q]  = 1'b1;
               end else begin
                  gnt_d[owner_q]   = 1'b1;
                  hold_d           = hold_q + 8'd1;
               end
`else
               gnt_d[owner_q] = 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= OW'(M-1);
         gnt_q   <= '{default: 1'b0};
`ifdef ARB_TIMEOUT_EN
         hold_q    <= '0;
         mask_q    <= '{default: 1'b0};
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
`ifdef ARB_TIMEOUT_EN
         hold_q    <= hold_d;
         mask_q    <= mask_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int unsigned i = 0; i < M; i++) begin
         busy = busy | gnt_q[i];
      end
   end

   assign gnt   = gnt_q;
   assign owner = owner_q;

`ifdef ARB_TIMEOUT_EN
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_array_rr_arbiter.sv
// Bench for array_rr_arbiter (M=4, MAX_HOLD=8): vector table, hand sequences and a one-hot monitor.
// The timeout sequence runs when ARB_TIMEOUT_EN is defined, the hold-forever sequence otherwise.
module tb_array_rr_arbiter;

   logic       clock;
   logic       reset;
   logic       req_s [4];
   logic       gnt_s [4];
   logic       busy;
   logic [1:0] owner;
   logic       timeout;
   logic [3:0] gnt_v;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [3:0] gnt;
      logic       busy;
      logic [1:0] owner;
      logic       tmo;
      string      nm;
   } exp_t;

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] owner;
      string      nm;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[$];

   array_rr_arbiter #(.M(4), .MAX_HOLD(8)) dut (
      .clock   (clock),
      .reset   (reset),
      .req     (req_s),
      .gnt     (gnt_s),
      .busy    (busy),
      .owner   (owner),
      .timeout (timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always_comb begin
      for (int i = 0; i < 4; i++) gnt_v[i] = gnt_s[i];
   end

   always @(negedge clock) begin
      tests++;
      if ($countones(gnt_v) > 1) begin
         fails++;
         $display("FAIL onehot: gnt=%b is multi-hot", gnt_v);
      end
   end

   task automatic drive_req(input logic [3:0] r);
      for (int i = 0; i < 4; i++) req_s[i] = r[i];
   endtask

   task automatic check_out();
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL scoreboard: no expectation queued");
         return;
      end
      e = sb.pop_front();
      if (gnt_v !== e.gnt || busy !== e.busy || owner !== e.owner || timeout !== e.tmo) begin
         fails++;
         $display("FAIL %s: got gnt=%b busy=%b owner=%0d timeout=%b, want gnt=%b busy=%b owner=%0d timeout=%b",
                  e.nm, gnt_v, busy, owner, timeout, e.gnt, e.busy, e.owner, e.tmo);
      end
   endtask

   task automatic apply(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] eo,
                        input logic et, input string nm);
      drive_req(r);
      sb.push_back('{eg, |eg, eo, et, nm});
      @(posedge clock);
      #1;
      check_out();
   endtask

   task automatic do_reset(input logic [3:0] r, input string nm);
      reset = 1'b1;
      drive_req(r);
      sb.push_back('{4'b0000, 1'b0, 2'd3, 1'b0, nm});
      @(posedge clock);
      #1;
      check_out();
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0] oh;
      reset = 1'b1;
      drive_req(4'b0000);
      repeat (2) @(posedge clock);
      #1;

      tbl.push_back('{4'b0100, 4'b0100, 2'd2, "t1_grant"});
      tbl.push_back('{4'b0100, 4'b0100, 2'd2, "t1_hold"});
      tbl.push_back('{4'b0000, 4'b0000, 2'd2, "t1_drop"});
      tbl.push_back('{4'b1000, 4'b1000, 2'd3, "own3"});
      tbl.push_back('{4'b0000, 4'b0000, 2'd3, "own3_idle"});
      tbl.push_back('{4'b1001, 4'b0001, 2'd0, "wrap"});
      tbl.push_back('{4'b1001, 4'b0001, 2'd0, "wrap_hold"});
      tbl.push_back('{4'b1000, 4'b0000, 2'd0, "wrap_drop"});
      tbl.push_back('{4'b1000, 4'b1000, 2'd3, "regrant3"});
      tbl.push_back('{4'b0000, 4'b0000, 2'd3, "idle3"});
      tbl.push_back('{4'b0010, 4'b0010, 2'd1, "own1"});
      tbl.push_back('{4'b1111, 4'b0010, 2'd1, "others_ignored"});
      tbl.push_back('{4'b1101, 4'b0000, 2'd1, "drop_same_edge"});
      tbl.push_back('{4'b1111, 4'b0100, 2'd2, "rr2"});
      tbl.push_back('{4'b1011, 4'b0000, 2'd2, "rr2_drop"});
      tbl.push_back('{4'b1111, 4'b1000, 2'd3, "rr3"});
      tbl.push_back('{4'b0111, 4'b0000, 2'd3, "rr3_drop"});
      tbl.push_back('{4'b1111, 4'b0001, 2'd0, "rr0"});
      tbl.push_back('{4'b1110, 4'b0000, 2'd0, "rr0_drop"});
      tbl.push_back('{4'b1111, 4'b0010, 2'd1, "rr1"});
      tbl.push_back('{4'b0000, 4'b0000, 2'd1, "final_idle"});

      do_reset(4'b0000, "reset_state");
      foreach (tbl[i]) apply(tbl[i].req, tbl[i].gnt, tbl[i].owner, 1'b0, tbl[i].nm);

      // All requesters held: order 0,1,2,3,0 with a single bubble after each 3-cycle run.
      do_reset(4'b0000, "t2_reset");
      for (int n = 0; n < 5; n++) begin
         oh = 4'b0001 << (n % 4);
         for (int c = 0; c < 3; c++) apply(4'b1111, oh, 2'(n % 4), 1'b0, "t2_run");
         apply(4'b1111 & ~oh, 4'b0000, 2'(n % 4), 1'b0, "t2_bubble");
      end

      // Reset while requester 1 owns the grant.
      do_reset(4'b0000, "t4_reset");
      apply(4'b0010, 4'b0010, 2'd1, 1'b0, "t4_grant1");
      do_reset(4'b0110, "t4_reset_mid_grant");
      apply(4'b0110, 4'b0010, 2'd1, 1'b0, "t4_restart");

`ifdef ARB_TIMEOUT_EN
      do_reset(4'b0000, "t5_reset");
      for (int c = 0; c < 8; c++) apply(4'b0010, 4'b0010, 2'd1, 1'b0, "t5_hold");
      apply(4'b0010, 4'b0000, 2'd1, 1'b1, "t5_revoke");
      for (int c = 0; c < 5; c++) apply(4'b0010, 4'b0000, 2'd1, 1'b0, "t5_masked");
      apply(4'b0000, 4'b0000, 2'd1, 1'b0, "t5_release");
      apply(4'b0010, 4'b0010, 2'd1, 1'b0, "t5_regrant");
`else
      do_reset(4'b0000, "t6_reset");
      for (int c = 0; c < 300; c++) apply(4'b0010, 4'b0010, 2'd1, 1'b0, "t6_hold");
`endif

      drive_req(4'b0000);
      @(posedge clock);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
